keypad_entry_buffer: RTL and testbench

KEYPAD_ENTRY_BUFFER -- requirements
Module: keypad_entry_buffer

---
 rtl/kpd_pkg.sv | 18 +
 rtl/digit_refresh.sv | 60 ++++++
 rtl/keypad_entry_buffer.sv | 159 +++++++++++++++
 tb/tb_keypad_entry_buffer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kpd_pkg.sv
// kpd_pkg: shared types and default timing constants for the keypad entry
// buffer (debounce FSM state encoding, debounce/refresh/auto-repeat defaults).
// No ports.
package kpd_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } kpd_state_t;

  localparam int KPD_DEBOUNCE_CYC     = 6000000;
  localparam int KPD_REFRESH_CYC      = 150000;
  localparam int KPD_REPEAT_DELAY_CYC = 6000000;
  localparam int KPD_REPEAT_RATE_CYC  = 1200000;

endpackage

// File: rtl/digit_refresh.sv
// digit_refresh: multiplexed display driver. Holds each digit for REFRESH_CYC
// clocks, then advances the one-hot select 0,1,..,NDIGITS-1,0.
// Ports:
//   clk       - clock
//   reset     - synchronous active-low reset (digit 0 selected, value 0)
//   digits    - 4*NDIGITS packed buffer, digit 0 in bits [3:0]
//   digit_en  - registered one-hot digit select
//   digit_val - registered hex value of the selected digit
module digit_refresh
  import kpd_pkg::*;
#(
  parameter int NDIGITS     = 2,
  parameter int REFRESH_CYC = KPD_REFRESH_CYC
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4*NDIGITS-1:0]   digits,
  output logic [NDIGITS-1:0]     digit_en,
  output logic [3:0]             digit_val
);

  localparam int RW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIGITS - 1);

  logic [RW-1:0] ref_cnt;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic          wrap;
  logic [3:0]    dig_arr [NDIGITS];

  for (genvar i = 0; i < NDIGITS; i++) begin : g_unpack
    assign dig_arr[i] = digits[4*i +: 4];
  end

  assign wrap = (ref_cnt == REF_LAST);

  always_comb begin
    idx_nxt = idx;
    if (wrap) idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
  end

  // digit_val is reloaded every cycle (not only on wrap) so a buffer shift
  // is reflected one cycle later even when it coincides with a wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ref_cnt   <= '0;
      idx       <= '0;
      digit_en  <= NDIGITS'(1);
      digit_val <= 4'h0;
    end else begin
      ref_cnt   <= wrap ? '0 : ref_cnt + RW'(1);
      idx       <= idx_nxt;
      digit_en  <= NDIGITS'(1) << idx_nxt;
      digit_val <= dig_arr[idx_nxt];
    end
  end

endmodule

// File: rtl/keypad_entry_buffer.sv
// keypad_entry_buffer: debounces a keypad key-down level, shifts each
// accepted key code into an NDIGITS-deep hex buffer and drives a
// multiplexed display of that buffer.
// Optional feature: define KPD_AUTOREPEAT_EN to re-accept a held key after
// REPEAT_DELAY_CYC clocks and then every REPEAT_RATE_CYC clocks.
// Ports:
//   clk         - clock
//   reset       - synchronous active-low reset
//   key_pressed - synchronized key-down level
//   key_code    - hex code of the key, valid while key_pressed is high
//   key_strobe  - one-cycle pulse per accepted key
//   key_val     - last accepted code
//   digits      - buffer contents, digit 0 (newest) in bits [3:0]
//   busy        - high whenever the debounce FSM is not IDLE
//   digit_en    - one-hot display digit select
//   digit_val   - hex value of the selected digit
//
// state      | meaning
// IDLE       | waiting for a key; a high key_pressed is accepted at once
// PRESS_DB   | key accepted, input ignored for DEBOUNCE_CYC cycles
// HELD       | key stable down; waiting for release (or auto-repeat)
// RELEASE_DB | needs DEBOUNCE_CYC consecutive low cycles to return to IDLE
module keypad_entry_buffer
  import kpd_pkg::*;
#(
  parameter int NDIGITS          = 2,
  parameter int DEBOUNCE_CYC     = KPD_DEBOUNCE_CYC,
  parameter int REFRESH_CYC      = KPD_REFRESH_CYC
`ifdef KPD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY_CYC = KPD_REPEAT_DELAY_CYC,
  parameter int REPEAT_RATE_CYC  = KPD_REPEAT_RATE_CYC
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 key_pressed,
  input  logic [3:0]           key_code,
  output logic                 key_strobe,
  output logic [3:0]           key_val,
  output logic [4*NDIGITS-1:0] digits,
  output logic                 busy,
  output logic [NDIGITS-1:0]   digit_en,
  output logic [3:0]           digit_val
);

  localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYC - 1);
  localparam logic [DBW-1:0] DB_MAX  = DBW'(DEBOUNCE_CYC);

  kpd_state_t           state;
  logic [DBW-1:0]       db_cnt;
  logic [4*NDIGITS-1:0] buf_q;
  logic [4*NDIGITS-1:0] buf_shift;
  logic                 accept;
  logic                 rpt_fire;

  if (NDIGITS == 1) begin : g_one
    assign buf_shift = key_code;
  end else begin : g_many
    assign buf_shift = {buf_q[4*NDIGITS-5:0], key_code};
  end

`ifdef KPD_AUTOREPEAT_EN
  localparam int RPT_MAXC = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC
                                                                  : REPEAT_RATE_CYC;
  localparam int RPW = $clog2(RPT_MAXC + 1);
  localparam logic [RPW-1:0] RPT_DELAY_LAST = RPW'(REPEAT_DELAY_CYC - 1);
  localparam logic [RPW-1:0] RPT_RATE_LAST  = RPW'(REPEAT_RATE_CYC - 1);
  localparam logic [RPW-1:0] RPT_MAX        = RPW'(RPT_MAXC);

  // Repeat timer runs from the accepting edge (through PRESS_DB), so the
  // first repeat lands REPEAT_DELAY_CYC cycles after the original strobe.
  logic [RPW-1:0] rpt_cnt;
  logic           rpt_phase;  // 0: initial delay, 1: repeat rate

  assign rpt_fire = (state == HELD) && key_pressed &&
                    (rpt_cnt == (rpt_phase ? RPT_RATE_LAST : RPT_DELAY_LAST));

  always_ff @(posedge clk) begin
    if (!reset) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else if (accept) begin
      rpt_cnt   <= '0;
      rpt_phase <= (state == HELD);
    end else if ((state == PRESS_DB || state == HELD) && rpt_cnt != RPT_MAX) begin
      rpt_cnt <= rpt_cnt + RPW'(1);
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  assign accept = ((state == IDLE) && key_pressed) || rpt_fire;
  assign digits = buf_q;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      db_cnt     <= '0;
      buf_q      <= '0;
      key_val    <= 4'h0;
      key_strobe <= 1'b0;
    end else begin
      key_strobe <= accept;
      if (accept) begin
        buf_q   <= buf_shift;
        key_val <= key_code;
      end
      case (state)
        IDLE: begin
          if (key_pressed) begin
            state  <= PRESS_DB;
            db_cnt <= '0;
          end
        end
        PRESS_DB: begin
          if (db_cnt == DB_LAST) begin
            state  <= HELD;
            db_cnt <= '0;
          end else if (db_cnt != DB_MAX) begin
            db_cnt <= db_cnt + DBW'(1);
          end
        end
        HELD: begin
          if (!key_pressed) begin
            state  <= RELEASE_DB;
            db_cnt <= '0;
          end
        end
        RELEASE_DB: begin
          if (key_pressed) begin
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else if (db_cnt != DB_MAX) begin
            db_cnt <= db_cnt + DBW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  digit_refresh #(
    .NDIGITS     (NDIGITS),
    .REFRESH_CYC (REFRESH_CYC)
  ) u_refresh (
    .clk       (clk),
    .reset     (reset),
    .digits    (buf_q),
    .digit_en  (digit_en),
    .digit_val (digit_val)
  );

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// tb_keypad_entry_buffer: self-checking bench for keypad_entry_buffer with
// NDIGITS=3, DEBOUNCE_CYC=8, REFRESH_CYC=4. Define KPD_AUTOREPEAT_EN to also
// exercise auto-repeat (REPEAT_DELAY_CYC=16, REPEAT_RATE_CYC=4).
// Every cycle is compared against a timeline-based reference model; segment
// tables and hand sequences add fixed expected values.
module tb_keypad_entry_buffer;

  localparam int ND = 3;
  localparam int DB = 8;
  localparam int RF = 4;
`ifdef KPD_AUTOREPEAT_EN
  localparam int RD = 16;
  localparam int RR = 4;
  localparam int PL = 14;   // press length kept below the repeat delay
`else
  localparam int PL = 20;
`endif

  logic          clk;
  logic          reset;
  logic          key_pressed;
  logic [3:0]    key_code;
  logic          key_strobe;
  logic [3:0]    key_val;
  logic [4*ND-1:0] digits;
  logic          busy;
  logic [ND-1:0] digit_en;
  logic [3:0]    digit_val;

  keypad_entry_buffer #(
    .NDIGITS          (ND),
    .DEBOUNCE_CYC     (DB),
    .REFRESH_CYC      (RF)
`ifdef KPD_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY_CYC (RD),
    .REPEAT_RATE_CYC  (RR)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_pressed (key_pressed),
    .key_code    (key_code),
    .key_strobe  (key_strobe),
    .key_val     (key_val),
    .digits      (digits),
    .busy        (busy),
    .digit_en    (digit_en),
    .digit_val   (digit_val)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (absolute-time view) ----------------
  bit         m_armed;
  int         m_edge;
  int         m_hold_from;
  int         m_acc_edge;
  bit         m_released;
  int         m_zeros;
  int         m_k;
  bit         m_strobe;
  logic [3:0] m_kval;
  logic [3:0] m_buf  [ND];
  logic [3:0] m_prev [ND];

  task automatic model_edge(input logic r, input logic kp, input logic [3:0] code);
    bit acc;
    if (!r) begin
      m_armed = 1; m_edge = 0; m_k = 0; m_strobe = 0; m_kval = 0;
      m_released = 0; m_zeros = 0; m_hold_from = 0; m_acc_edge = 0;
      for (int i = 0; i < ND; i++) begin m_buf[i] = 0; m_prev[i] = 0; end
      return;
    end
    for (int i = 0; i < ND; i++) m_prev[i] = m_buf[i];
    acc = 0;
    if (m_armed) begin
      if (kp) begin
        acc = 1; m_armed = 0; m_acc_edge = m_edge;
        m_hold_from = m_edge + DB + 1; m_released = 0;
      end
    end else if (m_edge >= m_hold_from) begin
      if (!m_released) begin
        if (!kp) begin
          m_released = 1; m_zeros = 0;
        end
`ifdef KPD_AUTOREPEAT_EN
        else if ((m_edge - m_acc_edge) >= RD && ((m_edge - m_acc_edge - RD) % RR) == 0)
          acc = 1;
`endif
      end else if (kp) begin
        m_zeros = 0;
      end else begin
        m_zeros++;
        if (m_zeros == DB) m_armed = 1;
      end
    end
    m_strobe = acc;
    if (acc) begin
      for (int i = ND - 1; i > 0; i--) m_buf[i] = m_buf[i-1];
      m_buf[0] = code;
      m_kval = code;
    end
    m_k++;
    m_edge++;
  endtask

  task automatic compare_all();
    logic [4*ND-1:0] exp_dig;
    int idx;
    for (int i = 0; i < ND; i++) exp_dig[4*i +: 4] = m_buf[i];
    idx = (m_k / RF) % ND;
    check("key_strobe", 32'(key_strobe), 32'(m_strobe));
    check("key_val",    32'(key_val),    32'(m_kval));
    check("digits",     32'(digits),     32'(exp_dig));
    check("busy",       32'(busy),       32'(!m_armed));
    check("digit_en",   32'(digit_en),   32'(1 << idx));
    check("digit_val",  32'(digit_val),  32'(m_prev[idx]));
  endtask

  task automatic tick(input logic r, input logic kp, input logic [3:0] code);
    reset = r; key_pressed = kp; key_code = code;
    @(posedge clk);
    model_edge(r, kp, code);
    #1;
    compare_all();
  endtask

  // ---------------- segment table ----------------
  typedef struct {
    logic        rst;
    logic        kp;
    logic [3:0]  code;
    int          len;
    logic [11:0] exp_digits;
    logic        exp_busy;
    int          exp_strobes;
  } seg_t;

  seg_t segs[17];
  logic [ND-1:0] exp_en[4];

  initial begin
    int nstr, n;
    reset = 1'b0; key_pressed = 1'b0; key_code = 4'h0;

    segs[0]  = '{1'b0, 1'b0, 4'h0, 2,  12'h000, 1'b0, 0};
    segs[1]  = '{1'b1, 1'b1, 4'h5, PL, 12'h005, 1'b1, 1};
    segs[2]  = '{1'b1, 1'b0, 4'h0, 20, 12'h005, 1'b0, 0};
    segs[3]  = '{1'b1, 1'b1, 4'hA, PL, 12'h05A, 1'b1, 1};
    segs[4]  = '{1'b1, 1'b0, 4'h0, 20, 12'h05A, 1'b0, 0};
    segs[5]  = '{1'b1, 1'b1, 4'h1, 12, 12'h5A1, 1'b1, 1};
    segs[6]  = '{1'b1, 1'b0, 4'h0, 12, 12'h5A1, 1'b0, 0};
    segs[7]  = '{1'b1, 1'b1, 4'h2, 12, 12'hA12, 1'b1, 1};
    segs[8]  = '{1'b1, 1'b0, 4'h0, 12, 12'hA12, 1'b0, 0};
    segs[9]  = '{1'b1, 1'b1, 4'h3, 12, 12'h123, 1'b1, 1};
    segs[10] = '{1'b1, 1'b0, 4'h0, 12, 12'h123, 1'b0, 0};
    segs[11] = '{1'b1, 1'b1, 4'h4, 12, 12'h234, 1'b1, 1};
    segs[12] = '{1'b1, 1'b0, 4'h0, 12, 12'h234, 1'b0, 0};
    segs[13] = '{1'b1, 1'b1, 4'h9, 3,  12'h349, 1'b1, 1};   // stop inside PRESS_DB
    segs[14] = '{1'b0, 1'b1, 4'h9, 1,  12'h000, 1'b0, 0};   // reset mid-press
    segs[15] = '{1'b1, 1'b1, 4'h9, 12, 12'h009, 1'b1, 1};   // held through reset release
    segs[16] = '{1'b1, 1'b0, 4'h0, 12, 12'h009, 1'b0, 0};

    exp_en[0] = 3'b001; exp_en[1] = 3'b010; exp_en[2] = 3'b100; exp_en[3] = 3'b001;

    for (int s = 0; s < 17; s++) begin
      nstr = 0;
      for (int c = 0; c < segs[s].len; c++) begin
        tick(segs[s].rst, segs[s].kp, segs[s].code);
        if (key_strobe) nstr++;
      end
      check($sformatf("seg%0d_digits", s),  32'(digits), 32'(segs[s].exp_digits));
      check($sformatf("seg%0d_busy", s),    32'(busy),   32'(segs[s].exp_busy));
      check($sformatf("seg%0d_strobes", s), 32'(nstr),   32'(segs[s].exp_strobes));
      if (s == 14) check("reset_digit_en", 32'(digit_en), 32'(3'b001));
    end

    // Bounce on press and on release: one strobe, idle 8 cycles after last high.
    nstr = 0;
    for (int c = 0; c < 22; c++) begin
      logic kp;
      if (c < 6)       kp = (c % 2 == 0);
      else if (c < 16) kp = 1'b1;
      else             kp = (c % 2 == 1);
      tick(1'b1, kp, 4'h3);
      if (key_strobe) nstr++;
    end
    n = 0;
    while (n < 20) begin
      tick(1'b1, 1'b0, 4'h0);
      n++;
      if (!busy) break;
    end
    check("bounce_strobes", 32'(nstr), 32'd1);
    check("bounce_idle_after", 32'(n), 32'd8);
    check("bounce_digits", 32'(digits), 32'h093);

    // Display rotation from reset, then a press landing on a wrap edge.
    tick(1'b0, 1'b0, 4'h0);
    for (int k = 1; k <= 11; k++) begin
      tick(1'b1, 1'b0, 4'h0);
      if (k % 4 == 2) check($sformatf("rot_en_k%0d", k), 32'(digit_en), 32'(exp_en[(k - 2) / 4]));
    end
    tick(1'b1, 1'b1, 4'h6);   // k=12: wrap back to digit 0
    check("wrap_en", 32'(digit_en), 32'(3'b001));
    check("wrap_val_same_edge", 32'(digit_val), 32'h0);
    tick(1'b1, 1'b1, 4'h6);
    check("wrap_val_next", 32'(digit_val), 32'h6);
    check("wrap_en_next", 32'(digit_en), 32'(exp_en[3]));
    for (int c = 0; c < 20; c++) tick(1'b1, 1'b0, 4'h0);

`ifdef KPD_AUTOREPEAT_EN
    tick(1'b0, 1'b0, 4'h0);
    for (int c = 1; c <= 30; c++) begin
      logic exp_s;
      tick(1'b1, 1'b1, 4'h7);
      exp_s = (c == 1 || c == 17 || c == 21 || c == 25 || c == 29);
      check($sformatf("rpt_strobe_c%0d", c), 32'(key_strobe), 32'(exp_s));
    end
    check("rpt_digits", 32'(digits), 32'h777);
    for (int c = 0; c < 20; c++) tick(1'b1, 1'b0, 4'h0);
`endif

    // Randomized runs against the model.
    for (int r = 0; r < 150; r++) begin
      logic kp;
      int len;
      logic [3:0] code;
      kp   = 1'($urandom_range(0, 1));
      len  = $urandom_range(1, 24);
      code = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) tick(1'b0, kp, code);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 9) == 0) code = 4'($urandom_range(0, 15));
        tick(1'b1, kp, code);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
